// File: rtl/cs_lbp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cs_lbp_pkg
// Brief    : Shared constants and FSM state encoding for the CS-LBP histogram.
// Revision : 1.0 - initial release
// ============================================================================
package cs_lbp_pkg;

    localparam int NUM_BINS      = 16;
    localparam int PATTERN_WIDTH = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } lbpState_t;

endpackage : cs_lbp_pkg
`default_nettype wire

// File: rtl/cs_lbp_histogram.sv
`default_nettype none
// ============================================================================
// Module   : cs_lbp_histogram
// Brief    : Accumulates CS-LBP codes into a 16-bin cell histogram, then
//            streams every bin out over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cs_lbp_histogram
    import cs_lbp_pkg::*;
#(
    parameter  int CELL_SIZE = 64,
    localparam int BIN_WIDTH = $clog2(CELL_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PATTERN_WIDTH-1:0] pattern_in,
    input  logic                     pattern_valid,
    output logic                     pattern_ready,
    input  logic                     flush,
    output logic [BIN_WIDTH-1:0]     bin_data,
    output logic [PATTERN_WIDTH-1:0] bin_index,
    output logic                     bin_valid,
    input  logic                     bin_ready,
    output logic                     bin_last
);

    localparam logic [BIN_WIDTH-1:0]     c_cellLast = BIN_WIDTH'(CELL_SIZE - 1);
    localparam logic [PATTERN_WIDTH-1:0] c_lastIdx  = PATTERN_WIDTH'(NUM_BINS - 1);
    localparam logic [BIN_WIDTH-1:0]     c_one      = BIN_WIDTH'(1);

    lbpState_t                r_state;
    lbpState_t                w_stateNext;
    logic [BIN_WIDTH-1:0]     r_hist [NUM_BINS];
    logic [BIN_WIDTH-1:0]     r_cellCnt;
    logic [PATTERN_WIDTH-1:0] r_drainIdx;
    logic                     w_accept;
    logic                     w_xfer;
    logic                     w_lastXfer;

    // All outputs derive from registered state only, so they hold during stalls.
    assign pattern_ready = (r_state == ACCUM);
    assign bin_valid     = (r_state == DRAIN);
    assign bin_index     = r_drainIdx;
    assign bin_data      = bin_valid ? r_hist[r_drainIdx] : '0;
    assign bin_last      = bin_valid && (r_drainIdx == c_lastIdx);

    assign w_accept   = pattern_valid && pattern_ready;
    assign w_xfer     = bin_valid && bin_ready;
    assign w_lastXfer = w_xfer && bin_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ACCUM: begin
                // A flush on an empty cell with no accept is a no-op.
                if ((w_accept && (r_cellCnt == c_cellLast)) ||
                    (flush && ((r_cellCnt != '0) || w_accept))) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (w_lastXfer) begin
                    w_stateNext = ACCUM;
                end
            end
            default: w_stateNext = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cellCnt  <= '0;
            r_drainIdx <= '0;
        end else begin
            if (w_accept) begin
                r_cellCnt <= r_cellCnt + c_one;
            end else if (w_lastXfer) begin
                r_cellCnt <= '0;
            end
            // Wraps 15 -> 0 on the final transfer, ready for the next cell.
            if (w_xfer) begin
                r_drainIdx <= r_drainIdx + PATTERN_WIDTH'(1);
            end
        end
    end

    // Accepts only occur in ACCUM and transfers only in DRAIN, so the two
    // updates never target the bin file in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                r_hist[b] <= '0;
            end
        end else if (w_accept) begin
            r_hist[pattern_in] <= r_hist[pattern_in] + c_one;
        end else if (w_xfer) begin
            r_hist[r_drainIdx] <= '0;
        end
    end

endmodule : cs_lbp_histogram
`default_nettype wire

// File: tb/tb_cs_lbp_histogram.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs_lbp_histogram
// Brief    : Scoreboard bench for cs_lbp_histogram with directed cells.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cs_lbp_histogram;

    localparam int CELL_SIZE = 64;
    localparam int BIN_WIDTH = 7;
    localparam int PERIOD    = 10;

    typedef struct {
        logic [3:0]           idx;
        logic [BIN_WIDTH-1:0] data;
        logic                 last;
    } binExp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [3:0]           pattern_in = '0;
    logic                 pattern_valid = 1'b0;
    logic                 pattern_ready;
    logic                 flush = 1'b0;
    logic [BIN_WIDTH-1:0] bin_data;
    logic [3:0]           bin_index;
    logic                 bin_valid;
    logic                 bin_ready = 1'b1;
    logic                 bin_last;

    binExp_t expQ[$];
    int      expHist [16];
    int      acceptCnt = 0;
    int      compared = 0;
    int      failed = 0;
    bit      randMode = 1'b0;
    bit      readyCheck = 1'b0;
    bit      prevStall = 1'b0;
    logic [3:0]           prevIdx = '0;
    logic [BIN_WIDTH-1:0] prevData = '0;
    logic                 prevLast = 1'b0;
    int      drainLen = 0;
    int      lastDrainLen = 0;
    time     lastXferTime = 0;

    cs_lbp_histogram #(.CELL_SIZE(CELL_SIZE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pattern_in    (pattern_in),
        .pattern_valid (pattern_valid),
        .pattern_ready (pattern_ready),
        .flush         (flush),
        .bin_data      (bin_data),
        .bin_index     (bin_index),
        .bin_valid     (bin_valid),
        .bin_ready     (bin_ready),
        .bin_last      (bin_last)
    );

    always #(PERIOD/2) clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bin_ready = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each bin transfer and checks handshake rules.
    always @(negedge clk) begin
        if (rst_n) begin
            if (readyCheck) begin
                readyCheck = 1'b0;
                check("ready_after_last", {31'd0, pattern_ready}, 32'd1);
                check("valid_after_last", {31'd0, bin_valid}, 32'd0);
            end
            if (bin_valid) begin
                drainLen++;
                check("ready_in_drain", {31'd0, pattern_ready}, 32'd0);
                if (prevStall) begin
                    check("stall_hold", {bin_last, bin_data, bin_index},
                          {prevLast, prevData, prevIdx});
                end
                if (bin_ready) begin
                    if (expQ.size() == 0) begin
                        compared++;
                        failed++;
                        $display("FAIL unexpected_bin: got idx %0d data %0d expected none at %0t",
                                 bin_index, bin_data, $time);
                    end else begin
                        binExp_t e;
                        e = expQ.pop_front();
                        check("bin", {bin_last, bin_data, bin_index}, {e.last, e.data, e.idx});
                    end
                    if (bin_last) begin
                        lastDrainLen = drainLen;
                        drainLen     = 0;
                        lastXferTime = $time;
                        readyCheck   = 1'b1;
                    end
                end
                prevStall = !bin_ready;
                prevIdx   = bin_index;
                prevData  = bin_data;
                prevLast  = bin_last;
            end else begin
                prevStall = 1'b0;
                drainLen  = 0;
            end
        end
    end

    task automatic pushCell();
        binExp_t e;
        for (int b = 0; b < 16; b++) begin
            e.idx  = 4'(b);
            e.data = BIN_WIDTH'(expHist[b]);
            e.last = (b == 15);
            expQ.push_back(e);
            expHist[b] = 0;
        end
        acceptCnt = 0;
    endtask

    task automatic clearModel();
        for (int b = 0; b < 16; b++) expHist[b] = 0;
        acceptCnt = 0;
    endtask

    // Called #1 after a posedge; leaves pattern_valid asserted.
    task automatic acceptOne(input logic [3:0] p, input bit chkStart);
        int  waited;
        time seenAt;
        waited = 0;
        pattern_valid = 1'b1;
        pattern_in    = p;
        @(negedge clk);
        while (!pattern_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!pattern_ready) begin
            compared++;
            failed++;
            $display("FAIL accept_timeout: got ready 0 expected 1 at %0t", $time);
            return;
        end
        seenAt = $time;
        @(posedge clk);
        expHist[p]++;
        acceptCnt++;
        if (chkStart) begin
            check("cell_restart_gap", 32'(seenAt - lastXferTime), 32'(PERIOD));
        end
        if (acceptCnt == CELL_SIZE) pushCell();
        #1;
    endtask

    task automatic doFlush();
        pattern_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        if (acceptCnt > 0) pushCell();
        #1;
        flush = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while ((expQ.size() != 0 || bin_valid) && n < 600) begin
            n++;
            @(negedge clk);
        end
        if (expQ.size() != 0 || bin_valid) begin
            compared++;
            failed++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_ready"}, {31'd0, pattern_ready}, 32'd1);
        check({tag, "_valid"}, {31'd0, bin_valid}, 32'd0);
        check({tag, "_data"},  {25'd0, bin_data}, 32'd0);
        check({tag, "_index"}, {28'd0, bin_index}, 32'd0);
        check({tag, "_last"},  {31'd0, bin_last}, 32'd0);
    endtask

    initial begin
        clearModel();
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-bin cell: 64 x pattern 5.
        for (int i = 0; i < CELL_SIZE; i++) acceptOne(4'd5, 1'b0);
        pattern_valid = 1'b0;
        waitIdle();

        // Uniform cell with bin_ready held high: 16 consecutive transfers.
        for (int r = 0; r < 4; r++)
            for (int p = 0; p < 16; p++) acceptOne(4'(p), 1'b0);
        pattern_valid = 1'b0;
        waitIdle();
        check("drain_len", 32'(lastDrainLen), 32'd16);

        // Partial cell closed by flush, then a flush on an empty cell.
        for (int i = 0; i < 10; i++) acceptOne(4'd3, 1'b0);
        doFlush();
        waitIdle();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("empty_flush_valid", {31'd0, bin_valid}, 32'd0);
            check("empty_flush_ready", {31'd0, pattern_ready}, 32'd1);
        end
        @(posedge clk);
        #1;

        // Uneven cell drained under random back-pressure.
        randMode = 1'b1;
        for (int i = 0; i < CELL_SIZE; i++) acceptOne(4'(i % 5), 1'b0);
        pattern_valid = 1'b0;
        waitIdle();
        randMode = 1'b0;

        // Mid-cell reset discards 30 accepts.
        for (int i = 0; i < 30; i++) acceptOne(4'd2, 1'b0);
        pattern_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checkResetOutputs("midreset");
        clearModel();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < CELL_SIZE; i++) acceptOne(4'd9, 1'b0);
        pattern_valid = 1'b0;
        waitIdle();

        // Back-to-back cells with pattern_valid never dropped.
        for (int i = 0; i < 2 * CELL_SIZE; i++) begin
            if (i < CELL_SIZE)          acceptOne(4'd7, 1'b0);
            else if (i < CELL_SIZE + 32) acceptOne(4'd12, i == CELL_SIZE);
            else                         acceptOne(4'd1, 1'b0);
        end
        pattern_valid = 1'b0;
        waitIdle();

        check("queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule : tb_cs_lbp_histogram
`default_nettype wire

// File: doc/cs_lbp_histogram.md
CS_LBP_HISTOGRAM -- requirements
Module: cs_lbp_histogram

Interface
REQ-001 SHALL have parameter CELL_SIZE, default 64, number of patterns per histogram cell; legal range 2..1023.
REQ-002 SHALL have derived localparam BIN_WIDTH, equal to clog2(CELL_SIZE+1), default 7; width of one bin count.
REQ-003 SHALL have port clk, input, 1 bit; single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-005 SHALL have port pattern_in, input, 4 bits; CS-LBP code, value 0..15.
REQ-006 SHALL have port pattern_valid, input, 1 bit; pattern_in is valid.
REQ-007 SHALL have port pattern_ready, output, 1 bit; block accepts a pattern this cycle.
REQ-008 SHALL have port flush, input, 1 bit; close the current partial cell.
REQ-009 SHALL have port bin_data, output, BIN_WIDTH bits; count for the current bin.
REQ-010 SHALL have port bin_index, output, 4 bits; bin number 0..15.
REQ-011 SHALL have port bin_valid, output, 1 bit; bin_data and bin_index are valid.
REQ-012 SHALL have port bin_ready, input, 1 bit; downstream accepts the bin.
REQ-013 SHALL have port bin_last, output, 1 bit; high with bin_index==15.

Function
REQ-014 SHALL implement a two-state FSM with states ACCUM and DRAIN; pattern_ready=1 only in ACCUM, bin_valid=1 only in DRAIN.
REQ-015 SHALL, in ACCUM, treat pattern_valid&&pattern_ready as an accept; each accept increments hist[pattern_in] by 1 and cell_cnt by 1 at the next edge.
REQ-016 SHALL, when an accept brings cell_cnt to CELL_SIZE, enter DRAIN on the next edge; the first bin_valid appears 1 cycle after the final accept.
REQ-017 SHALL, on flush in ACCUM with cell_cnt>0 or a same-cycle accept, apply any same-cycle accept and then enter DRAIN.
REQ-018 SHALL ignore flush when cell_cnt==0 and there is no accept; SHALL ignore flush in DRAIN.
REQ-019 SHALL, in DRAIN, drive bin_index=drain_idx, bin_data=hist[drain_idx], and bin_last=(drain_idx==15), all from registered state.
REQ-020 SHALL treat bin_valid&&bin_ready as a transfer; each transfer clears hist[drain_idx] to 0 and increments drain_idx.
REQ-021 SHALL hold bin_data, bin_index and bin_last stable while bin_valid=1 and bin_ready=0.
REQ-022 SHALL, on the transfer with bin_last=1, return to ACCUM with cell_cnt=0 and drain_idx=0; pattern_ready=1 in the following cycle.
REQ-023 SHALL never saturate or wrap a bin, because BIN_WIDTH holds CELL_SIZE; sum of the 16 drained bins equals patterns accepted in the cell.
REQ-024 SHALL emit all 16 bins, including zero bins, for every cell.
REQ-025 SHALL size cell_cnt at BIN_WIDTH bits.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force state=ACCUM, all 16 hist bins=0, cell_cnt=0, drain_idx=0.
REQ-027 SHALL reset outputs to pattern_ready=1, bin_valid=0, bin_data=0, bin_index=0, bin_last=0.
REQ-028 SHALL, if reset is asserted mid-cell or mid-drain, discard the partial histogram; the first cell after release starts empty.

Structure
REQ-029 SHALL place NUM_BINS=16, PATTERN_WIDTH=4 and the FSM state encoding in shared package cs_lbp_pkg.
REQ-030 SHALL keep the 16-entry bin register file inline; no sub-module is required.
REQ-031 SHALL be drop-in downstream of the CS-LBP pattern generator, connected pattern_in to lbpPattern.

Verification
REQ-032 SHALL cover: with CELL_SIZE=64, 64 accepts of pattern 5 -> bins 0..15 emitted, bin5=64, others 0, bin_last only on bin 15.
REQ-033 SHALL cover: patterns 0..15 each 4 times, bin_ready always 1 -> 16 consecutive transfers, each bin=4, DRAIN lasts 16 cycles.
REQ-034 SHALL cover: 10 accepts of pattern 3, then flush -> DRAIN with bin3=10, others 0; flush with cell_cnt=0 -> no state change.
REQ-035 SHALL cover: bin_ready toggled randomly during drain -> outputs stable while stalled, pattern_ready=0 throughout DRAIN, no bin lost or duplicated.
REQ-036 SHALL cover: rst_n pulsed low after 30 accepts -> all outputs at reset values; next 64 accepts of pattern 9 -> bin9=64 only.
REQ-037 SHALL cover: back-to-back cells with pattern_valid held at 1 -> second cell starts exactly 1 cycle after the bin_last transfer, and its histogram contains no residue from cell 1.
